peak_readout: RTL and testbench

//   Sits directly downstream of the peak_detect_fast chain and consumes its held_peak_final /

---
 rtl/peak_readout_if.sv | 30 +++
 rtl/peak_readout.sv | 139 +++++++++++++
 tb/tb_peak_readout.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/peak_readout_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | peak_readout_if : valid/ready stream carrying one ranked peak per beat    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface peak_readout_if #(
  parameter int VALUE_WIDTH = 16,
  parameter int INDEX_WIDTH = 12,
  parameter int RANK_W      = 2,
  parameter int FRAME_W     = 8
);
  logic                   m_valid;
  logic                   m_ready;
  logic [VALUE_WIDTH-1:0] m_peak;
  logic [INDEX_WIDTH-1:0] m_index;
  logic [RANK_W-1:0]      m_rank;
  logic                   m_last;
  logic [FRAME_W-1:0]     m_frame;

  modport master (
    output m_valid, m_peak, m_index, m_rank, m_last, m_frame,
    input  m_ready
  );

  modport slave (
    input  m_valid, m_peak, m_index, m_rank, m_last, m_frame,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/peak_readout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | peak_readout : snapshots the peak chain at frame end and streams it out   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module peak_readout #(
  parameter int VALUE_WIDTH = 16,
  parameter int INDEX_WIDTH = 12,
  parameter int NUM_PEAKS   = 3,
  parameter int FRAME_W     = 8
) (
  input  wire logic                             clk,
  input  wire logic                             reset,
  input  wire logic                             last_in,
  input  wire logic [NUM_PEAKS*VALUE_WIDTH-1:0] peaks_in,
  input  wire logic [NUM_PEAKS*INDEX_WIDTH-1:0] indexes_in,
  peak_readout_if.master                        m,
  output logic                                  overrun,
  output logic [7:0]                            overrun_cnt
);

  localparam int              RANK_W    = (NUM_PEAKS > 1) ? $clog2(NUM_PEAKS) : 1;
  localparam logic [RANK_W-1:0] LAST_RANK = RANK_W'(NUM_PEAKS - 1);
  localparam logic [7:0]      CNT_MAX   = 8'hFF;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                 state, state_nxt;
  logic [VALUE_WIDTH-1:0] snap_peak     [NUM_PEAKS];
  logic [VALUE_WIDTH-1:0] snap_peak_nxt [NUM_PEAKS];
  logic [INDEX_WIDTH-1:0] snap_idx      [NUM_PEAKS];
  logic [INDEX_WIDTH-1:0] snap_idx_nxt  [NUM_PEAKS];
  logic [RANK_W-1:0]      ptr, ptr_nxt, ptr_inc;
  logic [FRAME_W-1:0]     frame_cnt, frame_cnt_nxt;
  logic [FRAME_W-1:0]     frame_tag, frame_tag_nxt;

  logic                   out_valid, out_valid_nxt;
  logic [VALUE_WIDTH-1:0] out_peak, out_peak_nxt;
  logic [INDEX_WIDTH-1:0] out_index, out_index_nxt;
  logic                   out_last, out_last_nxt;
  logic                   overrun_nxt;
  logic [7:0]             overrun_cnt_nxt;

  logic hs, final_hs, accept, drop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= '0;
      frame_cnt   <= '0;
      frame_tag   <= '0;
      out_valid   <= 1'b0;
      out_peak    <= '0;
      out_index   <= '0;
      out_last    <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
      for (int k = 0; k < NUM_PEAKS; k++) begin
        snap_peak[k] <= '0;
        snap_idx[k]  <= '0;
      end
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      frame_cnt   <= frame_cnt_nxt;
      frame_tag   <= frame_tag_nxt;
      out_valid   <= out_valid_nxt;
      out_peak    <= out_peak_nxt;
      out_index   <= out_index_nxt;
      out_last    <= out_last_nxt;
      overrun     <= overrun_nxt;
      overrun_cnt <= overrun_cnt_nxt;
      for (int k = 0; k < NUM_PEAKS; k++) begin
        snap_peak[k] <= snap_peak_nxt[k];
        snap_idx[k]  <= snap_idx_nxt[k];
      end
    end
  end

  always_comb begin
    hs       = out_valid && m.m_ready;
    final_hs = hs && (ptr == LAST_RANK);
    // A frame end landing on the final beat is a seamless hand-over, not a drop.
    accept   = last_in && ((state == IDLE) || final_hs);
    drop     = last_in && (state == DRAIN) && !final_hs;
    ptr_inc  = ptr + RANK_W'(1);

    state_nxt       = state;
    ptr_nxt         = ptr;
    frame_cnt_nxt   = frame_cnt;
    frame_tag_nxt   = frame_tag;
    out_valid_nxt   = out_valid;
    out_peak_nxt    = out_peak;
    out_index_nxt   = out_index;
    out_last_nxt    = out_last;
    overrun_nxt     = drop;
    overrun_cnt_nxt = (drop && (overrun_cnt != CNT_MAX)) ? overrun_cnt + 8'd1 : overrun_cnt;
    for (int k = 0; k < NUM_PEAKS; k++) begin
      snap_peak_nxt[k] = snap_peak[k];
      snap_idx_nxt[k]  = snap_idx[k];
    end

    if (accept) begin
      for (int k = 0; k < NUM_PEAKS; k++) begin
        snap_peak_nxt[k] = peaks_in[k*VALUE_WIDTH +: VALUE_WIDTH];
        snap_idx_nxt[k]  = indexes_in[k*INDEX_WIDTH +: INDEX_WIDTH];
      end
      state_nxt     = DRAIN;
      ptr_nxt       = '0;
      frame_tag_nxt = frame_cnt;
      frame_cnt_nxt = frame_cnt + FRAME_W'(1);
      out_valid_nxt = 1'b1;
      out_peak_nxt  = peaks_in[VALUE_WIDTH-1:0];
      out_index_nxt = indexes_in[INDEX_WIDTH-1:0];
      out_last_nxt  = (NUM_PEAKS == 1);
    end else if (final_hs) begin
      state_nxt     = IDLE;
      out_valid_nxt = 1'b0;
    end else if (hs) begin
      ptr_nxt       = ptr_inc;
      out_peak_nxt  = snap_peak[ptr_inc];
      out_index_nxt = snap_idx[ptr_inc];
      out_last_nxt  = (ptr_inc == LAST_RANK);
    end
  end

  // ptr always mirrors the rank of the entry currently presented.
  assign m.m_valid = out_valid;
  assign m.m_peak  = out_peak;
  assign m.m_index = out_index;
  assign m.m_rank  = ptr;
  assign m.m_last  = out_last;
  assign m.m_frame = frame_tag;

endmodule
`default_nettype wire

// File: tb/tb_peak_readout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_peak_readout : directed self-checking bench for peak_readout           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_peak_readout;
  localparam int VW = 16;
  localparam int IW = 12;
  localparam int NP = 3;
  localparam int FW = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           last_in;
  logic [NP*VW-1:0] peaks_in;
  logic [NP*IW-1:0] indexes_in;
  logic           overrun;
  logic [7:0]     overrun_cnt;

  int compared = 0;
  int mismatched = 0;

  logic [39:0] got, exp;

  // Stimulus sets: stage k lives at [k*W +: W], stage 0 holds the largest.
  localparam logic [NP*VW-1:0] P1 = {16'd100, 16'd200, 16'd300};
  localparam logic [NP*IW-1:0] I1 = {12'h830, 12'h820, 12'h810};
  localparam logic [NP*VW-1:0] P2 = {16'd7, 16'd8, 16'd9};
  localparam logic [NP*IW-1:0] I2 = {12'h003, 12'h002, 12'h001};
  localparam logic [NP*VW-1:0] P3 = {16'd0, 16'd5000, 16'hFFFF};
  localparam logic [NP*IW-1:0] I3 = {12'hFFF, 12'h001, 12'h000};

  logic [VW-1:0] e1_pk [NP] = '{16'd300, 16'd200, 16'd100};
  logic [IW-1:0] e1_ix [NP] = '{12'h810, 12'h820, 12'h830};
  logic [VW-1:0] e3_pk [NP] = '{16'hFFFF, 16'd5000, 16'd0};
  logic [IW-1:0] e3_ix [NP] = '{12'h000, 12'h001, 12'hFFF};

  peak_readout_if #(.VALUE_WIDTH(VW), .INDEX_WIDTH(IW), .RANK_W(2), .FRAME_W(FW)) bus ();

  peak_readout #(
    .VALUE_WIDTH(VW), .INDEX_WIDTH(IW), .NUM_PEAKS(NP), .FRAME_W(FW)
  ) dut (
    .clk(clk), .reset(reset), .last_in(last_in), .peaks_in(peaks_in),
    .indexes_in(indexes_in), .m(bus.master), .overrun(overrun), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [NP*VW-1:0] p, input logic [NP*IW-1:0] ix);
    last_in = 1'b1;
    peaks_in = p;
    indexes_in = ix;
    tick();
    last_in = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; last_in = 1'b0; peaks_in = '0; indexes_in = '0; bus.m_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    compared++;
    got = {bus.m_valid, bus.m_peak, bus.m_index, bus.m_rank, bus.m_last, bus.m_frame};
    if (got !== 40'd0 || overrun !== 1'b0 || overrun_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL reset: got out=%h ovr=%b cnt=%0d expected all zero", got, overrun, overrun_cnt);
    end
  endtask

  task automatic test_basic();
    bus.m_ready = 1'b1;
    send(P1, I1);
    for (int k = 0; k < NP; k++) begin
      compared++;
      got = {bus.m_valid, bus.m_peak, bus.m_index, bus.m_rank, bus.m_last, bus.m_frame};
      exp = {1'b1, e1_pk[k], e1_ix[k], 2'(k), (k == NP-1), 8'd0};
      if (got !== exp) begin
        mismatched++;
        $display("FAIL basic entry %0d: got %h expected %h", k, got, exp);
      end
      tick();
    end
    compared++;
    if (bus.m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL basic end valid: got %b expected 0", bus.m_valid);
    end
  endtask

  task automatic test_stall();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int n = 0;
    send(P1, I1);
    for (int i = 0; i < 6; i++) begin
      bus.m_ready = pat[i];
      compared++;
      got = {bus.m_valid, bus.m_peak, bus.m_index, bus.m_rank, bus.m_last, bus.m_frame};
      exp = (n < NP) ? {1'b1, e1_pk[n], e1_ix[n], 2'(n), (n == NP-1), 8'd1} : 40'd0;
      if (got !== exp) begin
        mismatched++;
        $display("FAIL stall cycle %0d: got %h expected %h", i, got, exp);
      end
      if (bus.m_valid && bus.m_ready) n++;
      tick();
    end
    compared++;
    if (n !== NP || bus.m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL stall count: got %0d entries valid=%b expected 3 entries valid=0", n, bus.m_valid);
    end
  endtask

  task automatic test_overrun();
    bus.m_ready = 1'b0;
    send(P1, I1);
    send(P2, I2);
    compared++;
    if (overrun !== 1'b1 || overrun_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL overrun pulse: got ovr=%b cnt=%0d expected 1/1", overrun, overrun_cnt);
    end
    tick();
    compared++;
    if (overrun !== 1'b0 || overrun_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL overrun end: got ovr=%b cnt=%0d expected 0/1", overrun, overrun_cnt);
    end
    bus.m_ready = 1'b1;
    for (int k = 0; k < NP; k++) begin
      compared++;
      got = {bus.m_valid, bus.m_peak, bus.m_index, bus.m_rank, bus.m_last, bus.m_frame};
      exp = {1'b1, e1_pk[k], e1_ix[k], 2'(k), (k == NP-1), 8'd2};
      if (got !== exp) begin
        mismatched++;
        $display("FAIL overrun entry %0d: got %h expected %h", k, got, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    bus.m_ready = 1'b1;
    send(P1, I1);
    tick(); tick();
    last_in = 1'b1; peaks_in = P3; indexes_in = I3;
    compared++;
    got = {bus.m_valid, bus.m_peak, bus.m_index, bus.m_rank, bus.m_last, bus.m_frame};
    exp = {1'b1, e1_pk[2], e1_ix[2], 2'd2, 1'b1, 8'd3};
    if (got !== exp) begin
      mismatched++;
      $display("FAIL b2b tail: got %h expected %h", got, exp);
    end
    tick();
    last_in = 1'b0;
    for (int k = 0; k < NP; k++) begin
      compared++;
      got = {bus.m_valid, bus.m_peak, bus.m_index, bus.m_rank, bus.m_last, bus.m_frame};
      exp = {1'b1, e3_pk[k], e3_ix[k], 2'(k), (k == NP-1), 8'd4};
      if (got !== exp || overrun !== 1'b0 || overrun_cnt !== 8'd1) begin
        mismatched++;
        $display("FAIL b2b entry %0d: got %h ovr=%b cnt=%0d expected %h ovr=0 cnt=1",
                 k, got, overrun, overrun_cnt, exp);
      end
      tick();
    end
    compared++;
    if (bus.m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL b2b end valid: got %b expected 0", bus.m_valid);
    end
  endtask

  task automatic test_mid_reset();
    bus.m_ready = 1'b1;
    send(P1, I1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    compared++;
    if (bus.m_valid !== 1'b0 || overrun_cnt !== 8'd0 || bus.m_frame !== 8'd0) begin
      mismatched++;
      $display("FAIL mid reset: got valid=%b cnt=%0d frame=%0d expected 0/0/0",
               bus.m_valid, overrun_cnt, bus.m_frame);
    end
    tick(); tick();
    compared++;
    if (bus.m_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL mid reset idle: got valid=%b expected 0", bus.m_valid);
    end
    send(P1, I1);
    compared++;
    got = {bus.m_valid, bus.m_peak, bus.m_index, bus.m_rank, bus.m_last, bus.m_frame};
    exp = {1'b1, e1_pk[0], e1_ix[0], 2'd0, 1'b0, 8'd0};
    if (got !== exp) begin
      mismatched++;
      $display("FAIL post reset frame: got %h expected %h", got, exp);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_saturate();
    bus.m_ready = 1'b0;
    send(P1, I1);
    last_in = 1'b1; peaks_in = P2; indexes_in = I2;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 254 || i == 255 || i == 300) begin
        compared++;
        if (overrun_cnt !== ((i > 255) ? 8'd255 : 8'(i))) begin
          mismatched++;
          $display("FAIL saturate after %0d drops: got %0d expected %0d", i, overrun_cnt,
                   (i > 255) ? 255 : i);
        end
      end
    end
    last_in = 1'b0;
    bus.m_ready = 1'b1;
    compared++;
    got = {bus.m_valid, bus.m_peak, bus.m_index, bus.m_rank, bus.m_last, bus.m_frame};
    exp = {1'b1, e1_pk[0], e1_ix[0], 2'd0, 1'b0, 8'd1};
    if (got !== exp) begin
      mismatched++;
      $display("FAIL saturate held frame: got %h expected %h", got, exp);
    end
    tick(); tick(); tick();
  endtask

  task automatic test_wrap();
    logic [FW-1:0] tag;
    bus.m_ready = 1'b1;
    for (int f = 0; f < 257; f++) begin
      tag = FW'(f + 2);
      send(P2, I2);
      compared++;
      if (bus.m_valid !== 1'b1 || bus.m_frame !== tag) begin
        mismatched++;
        $display("FAIL wrap frame %0d: got valid=%b tag=%0d expected 1/%0d", f, bus.m_valid,
                 bus.m_frame, tag);
      end
      tick(); tick(); tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_saturate();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
